// File: rtl/mm_feeder_2x2.sv
// mm_feeder_2x2: operand feeder for the 2x2 systolic multiplier.
// Buffers a 2x2 A and a 2x2 B matrix, then streams A rows and B columns
// unskewed. After the stream it waits FLUSH_CYCLES idle cycles and then
// pulses done once the downstream products have settled.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   ld_valid/ld_ready        element write handshake (accepted in IDLE only)
//   ld_sel, ld_addr, ld_data matrix select (0=A,1=B), {row,col}, value
//   start                    begin streaming (sampled in IDLE only)
//   busy, done               run in progress / one-cycle completion pulse
//   a_row_*, b_col_*         streamed operands, each with a valid bit
module mm_feeder_2x2 #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             ld_sel,
    input  logic [1:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_row_0,
    output logic             a_row_0_valid,
    output logic [WIDTH-1:0] a_row_1,
    output logic             a_row_1_valid,
    output logic [WIDTH-1:0] b_col_0,
    output logic             b_col_0_valid,
    output logic [WIDTH-1:0] b_col_1,
    output logic             b_col_1_valid
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] S0    = 3'd1;
    localparam logic [2:0] S1    = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [CW-1:0]    cnt;
    logic             vld;

    // Storage index = {sel,row,col}: 0..3 hold A, 4..7 hold B.
    logic [WIDTH-1:0] mem   [0:7];
    logic [WIDTH-1:0] mem_n [0:7];

    logic [WIDTH-1:0] a0_n;
    logic [WIDTH-1:0] a1_n;
    logic [WIDTH-1:0] b0_n;
    logic [WIDTH-1:0] b1_n;

    // Post-write view of storage; feeding the k=0 beat from it lets a
    // write on the same edge as start reach the stream.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            mem_n[i] = mem[i];
        end
        if (state == IDLE && ld_valid) begin
            mem_n[{ld_sel, ld_addr}] = ld_data;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? S0 : IDLE;
            S0:      nxt = S1;
            S1:      nxt = FLUSH;
            FLUSH:   nxt = (cnt == '0) ? DONE : FLUSH;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        a0_n = '0;
        a1_n = '0;
        b0_n = '0;
        b1_n = '0;
        if (nxt == S0) begin
            a0_n = mem_n[0];
            a1_n = mem_n[2];
            b0_n = mem_n[4];
            b1_n = mem_n[5];
        end else if (nxt == S1) begin
            a0_n = mem_n[1];
            a1_n = mem_n[3];
            b0_n = mem_n[6];
            b1_n = mem_n[7];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            vld      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ld_ready <= 1'b1;
            a_row_0  <= '0;
            a_row_1  <= '0;
            b_col_0  <= '0;
            b_col_1  <= '0;
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= nxt;
            for (int i = 0; i < 8; i++) begin
                mem[i] <= mem_n[i];
            end
            if (state == S1) begin
                cnt <= FLUSH_LOAD;
            end else if (state == FLUSH && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            vld      <= (nxt == S0) || (nxt == S1);
            busy     <= (nxt != IDLE);
            done     <= (nxt == DONE);
            ld_ready <= (nxt == IDLE);
            a_row_0  <= a0_n;
            a_row_1  <= a1_n;
            b_col_0  <= b0_n;
            b_col_1  <= b1_n;
        end
    end

    assign a_row_0_valid = vld;
    assign a_row_1_valid = vld;
    assign b_col_0_valid = vld;
    assign b_col_1_valid = vld;

endmodule
